// File: rtl/add_result_queue_pkg.sv
// Shared constants for the adder result queue: default operand and tag
// widths (mirroring the ALU width header) and the stall counter width.
package add_result_queue_pkg;

    // Adder datapath width; must track the ALU's DATA_WIDTH.
    localparam int DATA_WIDTH    = 32;
    // Width of the tag carried alongside each ALU operation.
    localparam int ALU_TAG_WIDTH = 4;
    // Width of the saturating stall statistics counter.
    localparam int STALL_W       = 16;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Generic first-word-fall-through FIFO with push/pop and occupancy count.
// Ports: clock, reset (sync, active-high); push/push_data write side;
//   pop read side; head_valid/head_data show mem[rd_ptr] when non-empty
//   (head_data is 0 when empty); count = stored entries (0..DEPTH).
// A push while full is accepted only if a pop happens in the same cycle.
module result_fifo
    import add_result_queue_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = cnt_w(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    // When full the write slot equals the head slot, which is only safe
    // to overwrite because the head leaves in this same cycle.
    assign do_push    = push && ((count != FULL) || do_pop);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits so increments wrap on their own.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/add_result_queue.sv
// Result queue downstream of the adder: captures each result one cycle
// after its enable, tags it, buffers it in order and hands it to the
// consumer over valid/ready. issue_ok is a credit signal for upstream.
// Ports: clock, reset (sync, active-high); add_enable/add_tag issue side;
//   add_result (valid the cycle after add_enable); issue_ok credit out;
//   out_valid/out_ready/out_data/out_tag consumer side; count (stored
//   entries, excluding the in-flight op); overflow (sticky violation).
// Optional macro ADD_RESULT_QUEUE_STATS_EN adds stat_stall (saturating
//   stalled-head cycles) and stat_peak (highest count since reset).
module add_result_queue
    import add_result_queue_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH,
    parameter int TAG_W  = ALU_TAG_WIDTH,
    parameter int DEPTH  = 4,
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              add_enable,
    input  logic [TAG_W-1:0]  add_tag,
    input  logic [DATA_W-1:0] add_result,
    output logic              issue_ok,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CW-1:0]     count,
    output logic              overflow
`ifdef ADD_RESULT_QUEUE_STATS_EN
    ,
    output logic [STALL_W-1:0] stat_stall,
    output logic [CW-1:0]      stat_peak
`endif
);

    localparam int EW = DATA_W + TAG_W;

    logic             pend_q;
    logic [TAG_W-1:0] tag_q;
    logic [EW-1:0]    head;
    logic [CW:0]      used;

    // Enable in cycle N: the result arrives in N+1 and is pushed then.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= 1'b0;
            tag_q  <= '0;
        end else begin
            pend_q <= add_enable;
            tag_q  <= add_tag;
        end
    end

    result_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (pend_q),
        .push_data  ({add_result, tag_q}),
        .pop        (out_ready),
        .head_valid (out_valid),
        .head_data  (head),
        .count      (count)
    );

    assign out_data = head[EW-1:TAG_W];
    assign out_tag  = head[TAG_W-1:0];

    // The in-flight op already owns a slot, so it counts against credit.
    // Only registered state feeds this, never out_ready or add_enable.
    assign used     = {1'b0, count} + (CW+1)'(pend_q);
    assign issue_ok = (used < (CW+1)'(DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (add_enable && !issue_ok) begin
            overflow <= 1'b1;
        end
    end

`ifdef ADD_RESULT_QUEUE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_stall <= '0;
            stat_peak  <= '0;
        end else begin
            if (out_valid && !out_ready && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 1'b1;
            end
            if (count > stat_peak) begin
                stat_peak <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_add_result_queue.sv
// Directed bench for add_result_queue: single op, fill, streaming,
// violation while full, push+pop at full, and reset mid-operation.
module tb_add_result_queue;

    logic        clock;
    logic        reset;
    logic        add_enable;
    logic [3:0]  add_tag;
    logic [31:0] add_result;
    logic        issue_ok;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic [2:0]  count;
    logic        overflow;
`ifdef ADD_RESULT_QUEUE_STATS_EN
    logic [15:0] stat_stall;
    logic [2:0]  stat_peak;
`endif

    int vectors;
    int miscompares;

    logic       prev_en;
    logic [3:0] prev_tag;

    add_result_queue dut (
        .clock      (clock),
        .reset      (reset),
        .add_enable (add_enable),
        .add_tag    (add_tag),
        .add_result (add_result),
        .issue_ok   (issue_ok),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .count      (count),
        .overflow   (overflow)
`ifdef ADD_RESULT_QUEUE_STATS_EN
        ,
        .stat_stall (stat_stall),
        .stat_peak  (stat_peak)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Adder result for a given tag; tag 3 gives 7 as in the basic case.
    function automatic logic [31:0] res_of(input logic [3:0] t);
        return (t == 4'd3) ? 32'h0000_0007 : {t, 24'h5AC396, t};
    endfunction

    // One clock: drive inputs (result belongs to last cycle's op), then
    // step past the edge so checks see settled registered state.
    task automatic tick(input logic en, input logic [3:0] tag,
                        input logic rdy);
        add_result = prev_en ? res_of(prev_tag) : 32'hDEAD_BEEF;
        add_enable = en;
        add_tag    = tag;
        out_ready  = rdy;
        prev_en    = en;
        prev_tag   = tag;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        add_enable = 1'b0;
        add_tag    = '0;
        add_result = '0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset   = 1'b0;
        prev_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL rst_count: got %0d want 0", count);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_valid: got %b want 0", out_valid);
        end
        vectors++;
        if (out_data !== 32'h0 || out_tag !== 4'h0) begin
            miscompares++;
            $display("FAIL rst_data: got %h/%h want 0/0", out_data, out_tag);
        end
        vectors++;
        if (overflow !== 1'b0 || issue_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_flags: ovf %b ok %b want 0 1",
                     overflow, issue_ok);
        end
    endtask

    task automatic test_single();
        tick(1'b1, 4'd3, 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early: valid %b want 0", out_valid);
        end
        tick(1'b0, 4'd0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h7 || out_tag !== 4'd3) begin
            miscompares++;
            $display("FAIL single_out: v %b d %h t %0d want 1 7 3",
                     out_valid, out_data, out_tag);
        end
        vectors++;
        if (count !== 3'd1) begin
            miscompares++;
            $display("FAIL single_count: got %0d want 1", count);
        end
        tick(1'b0, 4'd0, 1'b1);
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pop: count %0d v %b want 0 0",
                     count, out_valid);
        end
    endtask

    task automatic test_streaming();
        int exp_tag;
        do_reset();
        exp_tag = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                vectors++;
                if (issue_ok !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_ok[%0d]: got %b want 1", i, issue_ok);
                end
            end
            vectors++;
            if (count > 3'd1) begin
                miscompares++;
                $display("FAIL stream_count[%0d]: got %0d want <=1", i, count);
            end
            if (out_valid) begin
                vectors++;
                if (out_tag !== 4'(exp_tag) ||
                    out_data !== res_of(4'(exp_tag))) begin
                    miscompares++;
                    $display("FAIL stream_order: got %0d/%h want %0d/%h",
                             out_tag, out_data, exp_tag, res_of(4'(exp_tag)));
                end
                exp_tag++;
            end
            tick(i < 16, 4'(i), 1'b1);
        end
        vectors++;
        if (exp_tag != 16 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL stream_total: got %0d cnt %0d want 16 0",
                     exp_tag, count);
        end
    endtask

    task automatic test_fill();
        int  accepted;
        bit  seen_block;
        do_reset();
        accepted   = 0;
        seen_block = 0;
        for (int i = 0; i < 8; i++) begin
            if (issue_ok) begin
                tick(1'b1, 4'(accepted), 1'b0);
                accepted++;
            end else begin
                if (!seen_block) begin
                    seen_block = 1;
                    vectors++;
                    if (count !== 3'd3) begin
                        miscompares++;
                        $display("FAIL fill_block_at: count %0d want 3", count);
                    end
                end
                tick(1'b0, 4'd0, 1'b0);
            end
        end
        vectors++;
        if (accepted != 4) begin
            miscompares++;
            $display("FAIL fill_accepted: got %0d want 4", accepted);
        end
        vectors++;
        if (count !== 3'd4 || issue_ok !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_state: cnt %0d ok %b ovf %b want 4 0 0",
                     count, issue_ok, overflow);
        end
        vectors++;
        if (out_tag !== 4'd0 || out_data !== res_of(4'd0)) begin
            miscompares++;
            $display("FAIL fill_head: got %0d/%h want 0/%h",
                     out_tag, out_data, res_of(4'd0));
        end
`ifdef ADD_RESULT_QUEUE_STATS_EN
        vectors++;
        if (stat_peak !== 3'd4) begin
            miscompares++;
            $display("FAIL fill_peak: got %0d want 4", stat_peak);
        end
`endif
    endtask

    task automatic test_violation();
        tick(1'b1, 4'd8, 1'b0);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL viol_flag: got %b want 1", overflow);
        end
        tick(1'b0, 4'd0, 1'b0);
        vectors++;
        if (count !== 3'd4 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL viol_state: cnt %0d ovf %b want 4 1",
                     count, overflow);
        end
        vectors++;
        if (out_tag !== 4'd0 || out_data !== res_of(4'd0)) begin
            miscompares++;
            $display("FAIL viol_head: got %0d/%h want 0/%h",
                     out_tag, out_data, res_of(4'd0));
        end
    endtask

    task automatic test_full_push_pop();
        logic [3:0] exp [4];
        exp[0] = 4'd1;
        exp[1] = 4'd2;
        exp[2] = 4'd3;
        exp[3] = 4'd9;
        tick(1'b1, 4'd9, 1'b0);
        tick(1'b0, 4'd0, 1'b1);
        vectors++;
        if (count !== 3'd4) begin
            miscompares++;
            $display("FAIL fullpp_count: got %0d want 4", count);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_tag !== exp[k] ||
                out_data !== res_of(exp[k])) begin
                miscompares++;
                $display("FAIL fullpp_order[%0d]: v %b got %0d/%h want %0d/%h",
                         k, out_valid, out_tag, out_data, exp[k],
                         res_of(exp[k]));
            end
            tick(1'b0, 4'd0, 1'b1);
        end
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL fullpp_drain: cnt %0d v %b ovf %b want 0 0 1",
                     count, out_valid, overflow);
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 4'(i + 4), 1'b0);
        end
        vectors++;
        if (count !== 3'd3 || issue_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_pre: cnt %0d ok %b want 3 0", count, issue_ok);
        end
        reset = 1'b1;
        tick(1'b0, 4'd0, 1'b0);
        reset = 1'b0;
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0 ||
            overflow !== 1'b0 || issue_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_rst: cnt %0d v %b ovf %b ok %b want 0 0 0 1",
                     count, out_valid, overflow, issue_ok);
        end
`ifdef ADD_RESULT_QUEUE_STATS_EN
        vectors++;
        if (stat_stall !== 16'd0 || stat_peak !== 3'd0) begin
            miscompares++;
            $display("FAIL midop_stats: stall %0d peak %0d want 0 0",
                     stat_stall, stat_peak);
        end
`endif
        tick(1'b0, 4'd0, 1'b0);
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_after: cnt %0d v %b want 0 0",
                     count, out_valid);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        prev_en     = 1'b0;
        prev_tag    = '0;
        reset       = 1'b1;
        add_enable  = 1'b0;
        add_tag     = '0;
        add_result  = '0;
        out_ready   = 1'b0;
        test_reset();
        test_single();
        test_streaming();
        test_fill();
        test_violation();
        test_full_push_pop();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
